cla_multiword_adder: RTL
========================

CLA_MULTIWORD_ADDER -- requirements
Module: cla_multiword_adder

Interface
REQ-001 SHALL have no parameters; the datapath chunk width is fixed at 5 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block can accept a beat.
REQ-006 in_a, in_b  input  5 each  operand chunks, least-significant chunk first.
REQ-007 in_first, in_last  input  1 each  beat is the first / last chunk of an operand pair.
REQ-008 cin_ext  input  1  carry-in applied to the first beat.
REQ-009 out_valid  output  1  result beat available.
REQ-010 out_ready  input  1  consumer accepts the result beat.
REQ-011 out_sum  output  5  sum chunk.
REQ-012 out_cout, out_last  output  1 each  chunk carry-out; last-chunk marker.
REQ-013 out_ovf  output  1  signed-overflow flag (see Configuration).
REQ-014 err  output  1  sticky framing-error flag.
REQ-015 pkt_cnt  output  8  count of completed packets.

Function
REQ-016 Beat transfer SHALL occur when in_valid && in_ready; result transfer SHALL occur when out_valid && out_ready.
REQ-017 Each accepted beat SHALL compute {cout,sum} = in_a + in_b + c_sel with a 5-bit carry-lookahead adder, combinational within one cycle.
REQ-018 c_sel SHALL be cin_ext when the beat is treated as first, otherwise the carry register c_reg.
REQ-019 On acceptance, c_reg SHALL load the chunk's cout; on an accepted last beat it SHALL clear to 0.
REQ-020 FSM states: IDLE (expects first beat), RUN (mid-packet).
REQ-021 IDLE to RUN on an accepted beat with in_last=0; any accepted beat with in_last=1 SHALL return to, or remain in, IDLE.
REQ-022 Beat with in_first=0 accepted in IDLE: SHALL be treated as first (c_sel=cin_ext), and err SHALL be set.
REQ-023 Beat with in_first=1 accepted in RUN: SHALL restart the packet (c_sel=cin_ext), and err SHALL be set.
REQ-024 A beat with in_first=1 and in_last=1 SHALL be a complete single-chunk packet.
REQ-025 Results SHALL enter a 2-entry FIFO; the oldest entry drives the out_* ports; output order equals input order.
REQ-026 Latency: a beat accepted at edge N SHALL produce out_valid=1 after edge N when the FIFO was empty.
REQ-027 in_ready SHALL be 1 iff the FIFO count < 2, registered, with no combinational dependence on out_ready.
REQ-028 Simultaneous push and pop SHALL leave the count unchanged and lose no data.
REQ-029 out_* ports SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 pkt_cnt SHALL increment on every accepted last beat and wrap from 255 to 0.
REQ-031 err SHALL remain set until reset.

Reset
REQ-032 On rst_n=0, the block SHALL immediately clear FSM=IDLE, c_reg=0, FIFO count=0, out_valid=0, out_sum=0, out_cout=0, out_last=0, out_ovf=0, err=0, pkt_cnt=0.
REQ-033 in_ready SHALL be 0 during reset and 1 on the first edge after release.
REQ-034 Reset asserted mid-packet SHALL discard all partial state and buffered results.

Configuration
REQ-035 With macro CLA_OVF_FLAG_EN defined, out_ovf SHALL equal carry-into-bit4 XOR carry-out-of-bit4 for last beats, stored per FIFO entry, and 0 for non-last beats.
REQ-036 With CLA_OVF_FLAG_EN undefined, out_ovf SHALL be tied to 0 and no overflow logic SHALL be synthesised.

Verification
REQ-037 Single beat a=0x0F, b=0x01, cin_ext=0, first=last=1 -> next cycle out_sum=0x10, out_cout=0, out_last=1, pkt_cnt=1.
REQ-038 Two beats (0x1F,0x01,first) then (0x00,0x00,last) -> out_sum 0x00/cout=1, then out_sum 0x01/cout=0/last=1.
REQ-039 out_ready=0 with 3 beats offered back-to-back -> 2 beats accepted, in_ready=0; then out_ready=1 -> results drain in order and the third beat is accepted.
REQ-040 Beat with first=0 in IDLE, cin_ext=1, a=b=0 -> out_sum=0x01, err=1 persists.
REQ-041 rst_n pulsed low after the first of a 3-beat packet -> all outputs 0, FIFO empty, and the next first beat uses cin_ext.
REQ-042 a=0x0F, b=0x01, first=last=1 -> out_ovf=1 with CLA_OVF_FLAG_EN defined, 0 without it.

Source files
------------

// File: rtl/cla_multiword_adder.sv
// ---------------------------------------------------------------------------
// cla_multiword_adder
//
// Purpose: adds wide operands that arrive as a stream of 5-bit chunks, least
// significant chunk first. Each accepted beat goes through a 5-bit
// carry-lookahead adder. The carry is kept in c_reg from one beat to the next.
// Results are buffered in a 2-entry FIFO.
//
// Optional feature: define CLA_OVF_FLAG_EN to produce a signed-overflow flag
// on the last chunk of each packet. When it is undefined, out_ovf is tied to 0.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (in_ready is registered)
//   in_a, in_b          5-bit operand chunks
//   in_first, in_last   packet framing markers for the beat
//   cin_ext             carry-in used by the first beat of a packet
//   out_valid/out_ready result handshake
//   out_sum, out_cout   sum chunk and chunk carry-out
//   out_last, out_ovf   last-chunk marker, signed-overflow flag
//   err                 sticky framing-error flag
//   pkt_cnt             completed-packet counter (wraps at 256)
// ---------------------------------------------------------------------------
module cla_multiword_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_a,
    input  logic [4:0] in_b,
    input  logic       in_first,
    input  logic       in_last,
    input  logic       cin_ext,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_sum,
    output logic       out_cout,
    output logic       out_last,
    output logic       out_ovf,
    output logic       err,
    output logic [7:0] pkt_cnt
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic        c_reg, c_next;
    logic        err_reg, err_next;
    logic [7:0]  pkt_cnt_reg, pkt_cnt_next;
    logic [1:0]  count_reg, count_next;
    logic        wr_ptr_reg, rd_ptr_reg;
    logic        in_ready_reg;

    logic        push, pop;
    logic        treat_first;
    logic        c_sel;

    // ---------------------------------------------------------------------
    // 5-bit carry-lookahead adder. Each carry is computed as a flat
    // sum-of-products of generate/propagate terms, so no carry ripples
    // from one bit position to the next.
    // ---------------------------------------------------------------------
    logic [4:0] gen, prop;
    logic [4:0] carry_out;   // carry_out[k] = carry out of bit k
    logic [4:0] carry_in;    // carry_in[k]  = carry into bit k
    logic [4:0] sum_beat;

    function automatic logic cla_carry(input logic [4:0] g, input logic [4:0] p,
                                       input logic c0, input int k);
        logic acc;
        logic pchain;
        acc    = g[k];
        pchain = p[k];
        for (int j = 3; j >= 0; j--) begin
            if (j < k) begin
                acc    = acc | (pchain & g[j]);
                pchain = pchain & p[j];
            end
        end
        return acc | (pchain & c0);
    endfunction

    assign gen  = in_a & in_b;
    assign prop = in_a ^ in_b;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cla
            assign carry_out[gi] = cla_carry(gen, prop, c_sel, gi);
            if (gi == 0) begin : g_c0
                assign carry_in[gi] = c_sel;
            end else begin : g_cn
                assign carry_in[gi] = carry_out[gi-1];
            end
            assign sum_beat[gi] = prop[gi] ^ carry_in[gi];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Handshake and framing
    // ---------------------------------------------------------------------
    assign in_ready  = in_ready_reg;
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid & in_ready_reg;
    assign pop       = out_valid & out_ready;

    // A beat restarts the carry chain when the FSM is waiting for a first
    // beat, or when the beat itself claims to be first. The two framing
    // errors are handled the same way: the beat is processed as a first
    // beat and the error is logged.
    assign treat_first = (state_reg == IDLE) | in_first;
    assign c_sel       = treat_first ? cin_ext : c_reg;

    always_comb begin
        state_next   = state_reg;
        c_next       = c_reg;
        err_next     = err_reg;
        pkt_cnt_next = pkt_cnt_reg;
        if (push) begin
            if ((state_reg == IDLE && !in_first) || (state_reg == RUN && in_first))
                err_next = 1'b1;
            if (in_last) begin
                state_next   = IDLE;
                c_next       = 1'b0;
                pkt_cnt_next = pkt_cnt_reg + 8'd1;
            end else begin
                state_next = RUN;
                c_next     = carry_out[4];
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            c_reg        <= 1'b0;
            err_reg      <= 1'b0;
            pkt_cnt_reg  <= 8'd0;
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            c_reg        <= c_next;
            err_reg      <= err_next;
            pkt_cnt_reg  <= pkt_cnt_next;
            count_reg    <= count_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            // Registered so that in_ready never depends on out_ready.
            in_ready_reg <= (count_next < 2'd2);
        end
    end

    assign err     = err_reg;
    assign pkt_cnt = pkt_cnt_reg;

    // ---------------------------------------------------------------------
    // 2-entry result FIFO. The entries are reset so that the out_* ports
    // read as zero after reset. The oldest entry drives the outputs.
    // ---------------------------------------------------------------------
    logic [4:0] sum_mem  [2];
    logic       cout_mem [2];
    logic       last_mem [2];

`ifdef CLA_OVF_FLAG_EN
    logic       ovf_mem  [2];
    logic       ovf_beat;
    // The signed-overflow flag only has meaning on the most significant chunk.
    assign ovf_beat = in_last & (carry_out[3] ^ carry_out[4]);
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_mem[gi]  <= 5'd0;
                    cout_mem[gi] <= 1'b0;
                    last_mem[gi] <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
                    ovf_mem[gi]  <= 1'b0;
`endif
                end else if (push && (wr_ptr_reg == gi[0])) begin
                    sum_mem[gi]  <= sum_beat;
                    cout_mem[gi] <= carry_out[4];
                    last_mem[gi] <= in_last;
`ifdef CLA_OVF_FLAG_EN
                    ovf_mem[gi]  <= ovf_beat;
`endif
                end
            end
        end
    endgenerate

    assign out_sum  = sum_mem[rd_ptr_reg];
    assign out_cout = cout_mem[rd_ptr_reg];
    assign out_last = last_mem[rd_ptr_reg];
`ifdef CLA_OVF_FLAG_EN
    assign out_ovf  = ovf_mem[rd_ptr_reg];
`else
    assign out_ovf  = 1'b0;
`endif

endmodule
